// File: rtl/puf_ro_resp_gen.sv
// Ring-oscillator PUF response generator: counts synchronised RO rising edges per challenge pair and compares.
// Latency RESP_BITS*(WINDOW+2)+1 cycles start->done; no backpressure, start is ignored while busy.
module puf_ro_resp_gen #(
    parameter int  NUM_RO    = 8,
    parameter int  RESP_BITS = 4,
    parameter int  WINDOW    = 1024,
    parameter int  CNT_W     = 16,
    parameter int  THRESH    = 2,
    localparam int SEL_W     = $clog2(NUM_RO),
    localparam int CHAL_W    = RESP_BITS * 2 * SEL_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_enable,
    input  logic                 i_start,
    input  logic [CHAL_W-1:0]    i_challenge,
    input  logic [NUM_RO-1:0]    i_ro_in,
    output logic                 o_ro_en,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [RESP_BITS-1:0] o_response,
    output logic [RESP_BITS-1:0] o_unstable
);
    localparam int BIT_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int WIN_W = $clog2(WINDOW);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COUNT,
        S_CMP,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NUM_RO-1:0]    r_sync1;
    logic [NUM_RO-1:0]    r_sync2;
    logic [NUM_RO-1:0]    r_hist;
    logic [NUM_RO-1:0]    w_edge;
    logic [CHAL_W-1:0]    r_chal;
    logic [BIT_W-1:0]     r_bit;
    logic [WIN_W-1:0]     r_win;
    logic [CNT_W-1:0]     r_cnt_a;
    logic [CNT_W-1:0]     r_cnt_b;
    logic [RESP_BITS-1:0] r_response;
    logic [RESP_BITS-1:0] r_unstable;
    logic [SEL_W-1:0]     w_sel_a;
    logic [SEL_W-1:0]     w_sel_b;
    logic                 w_edge_a;
    logic                 w_edge_b;
    logic                 w_win_last;
    logic                 w_last_bit;
    logic                 w_gt;
    logic [CNT_W:0]       w_diff;
    logic                 w_accept;
    logic                 w_abort;
    logic                 w_ro_en;
    logic                 w_busy;
    logic                 w_done;

    // Rising edges only, seen after the two-flop synchroniser.
    assign w_edge     = r_sync2 & ~r_hist;
    assign w_sel_a    = r_chal[(2 * int'(r_bit)) * SEL_W +: SEL_W];
    assign w_sel_b    = r_chal[(2 * int'(r_bit) + 1) * SEL_W +: SEL_W];
    assign w_edge_a   = w_edge[w_sel_a];
    assign w_edge_b   = w_edge[w_sel_b];
    assign w_win_last = (r_win == WIN_W'(WINDOW - 1));
    assign w_last_bit = (r_bit == BIT_W'(RESP_BITS - 1));
    assign w_gt       = (r_cnt_a > r_cnt_b);
    assign w_diff     = w_gt ? ({1'b0, r_cnt_a} - {1'b0, r_cnt_b})
                             : ({1'b0, r_cnt_b} - {1'b0, r_cnt_a});

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_abort     = 1'b0;
        w_ro_en     = 1'b0;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (i_start && i_enable) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_ro_en     = 1'b1;
                w_state_nxt = S_COUNT;
            end
            S_COUNT: begin
                w_ro_en = 1'b1;
                if (w_win_last) begin
                    w_state_nxt = S_CMP;
                end
            end
            S_CMP: begin
                w_state_nxt = w_last_bit ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Dropping enable anywhere outside IDLE abandons the run without a done pulse.
        if ((r_state != S_IDLE) && !i_enable) begin
            w_abort     = 1'b1;
            w_done      = 1'b0;
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_hist     <= '0;
            r_chal     <= '0;
            r_bit      <= '0;
            r_win      <= '0;
            r_cnt_a    <= '0;
            r_cnt_b    <= '0;
            r_response <= '0;
            r_unstable <= '0;
        end else begin
            r_sync1 <= i_ro_in;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
            if (w_abort) begin
                r_response <= '0;
                r_unstable <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_chal     <= i_challenge;
                            r_bit      <= '0;
                            r_response <= '0;
                            r_unstable <= '0;
                        end
                    end
                    S_LOAD: begin
                        r_cnt_a <= '0;
                        r_cnt_b <= '0;
                        r_win   <= '0;
                    end
                    S_COUNT: begin
                        r_win <= r_win + WIN_W'(1);
                        if (w_edge_a && (r_cnt_a != CNT_MAX)) begin
                            r_cnt_a <= r_cnt_a + CNT_W'(1);
                        end
                        if (w_edge_b && (r_cnt_b != CNT_MAX)) begin
                            r_cnt_b <= r_cnt_b + CNT_W'(1);
                        end
                    end
                    S_CMP: begin
                        r_response[r_bit] <= w_gt;
                        r_unstable[r_bit] <= (w_diff < (CNT_W + 1)'(THRESH));
                        if (!w_last_bit) begin
                            r_bit <= r_bit + BIT_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_ro_en    = w_ro_en;
    assign o_busy     = w_busy;
    assign o_done     = w_done;
    assign o_response = r_response;
    assign o_unstable = r_unstable;

endmodule

// File: tb/tb_puf_ro_resp_gen.sv
// Bench for puf_ro_resp_gen: periodic RO stimulus, edge-count reference model, queue scoreboard.
module tb_puf_ro_resp_gen;
    localparam int NUM_RO    = 8;
    localparam int RESP_BITS = 4;
    localparam int WINDOW    = 64;
    localparam int CNT_W     = 16;
    localparam int THRESH    = 2;
    localparam int SEL_W     = 3;
    localparam int CHAL_W    = RESP_BITS * 2 * SEL_W;
    localparam int LAT       = RESP_BITS * (WINDOW + 2) + 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable;
    logic                 start;
    logic [CHAL_W-1:0]    challenge;
    logic [NUM_RO-1:0]    ro_in;
    logic                 ro_en;
    logic                 busy;
    logic                 done;
    logic [RESP_BITS-1:0] response;
    logic [RESP_BITS-1:0] unstable;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int per[NUM_RO];
    int ph[NUM_RO];
    int divs[7] = '{0, 2, 4, 8, 16, 32, 64};
    logic [7:0] exp_q[$];
    int         cyc_q[$];
    logic [7:0] mon_e;
    int         mon_c;
    int         en_len   = 0;
    bit         skip_len = 1'b0;
    logic [CHAL_W-1:0] basic_ch;

    puf_ro_resp_gen #(
        .NUM_RO(NUM_RO), .RESP_BITS(RESP_BITS), .WINDOW(WINDOW), .CNT_W(CNT_W), .THRESH(THRESH)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_start(start), .i_challenge(challenge),
        .i_ro_in(ro_in), .o_ro_en(ro_en), .o_busy(busy), .o_done(done),
        .o_response(response), .o_unstable(unstable)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Square-wave ROs, changed on the falling clock edge; period 0 means the RO is idle.
    always @(negedge clk) begin
        for (int i = 0; i < NUM_RO; i++) begin
            ro_in[i] = (per[i] == 0) ? 1'b0 : (((cyc + ph[i]) % per[i]) < (per[i] / 2));
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [CHAL_W-1:0] mkch(input int a0, b0, a1, b1, a2, b2, a3, b3);
        return {3'(b3), 3'(a3), 3'(b2), 3'(a2), 3'(b1), 3'(a1), 3'(b0), 3'(a0)};
    endfunction

    // Rising edges of a periodic square wave in any WINDOW-cycle span (exact when period divides WINDOW).
    function automatic int edges(input int sel);
        return (per[sel] == 0) ? 0 : WINDOW / per[sel];
    endfunction

    function automatic logic [7:0] model(input logic [CHAL_W-1:0] ch);
        logic [3:0] r;
        logic [3:0] u;
        int a, b, ca, cb, d;
        r = '0;
        u = '0;
        for (int i = 0; i < RESP_BITS; i++) begin
            a  = int'(ch[2 * i * SEL_W +: SEL_W]);
            b  = int'(ch[(2 * i + 1) * SEL_W +: SEL_W]);
            ca = edges(a);
            cb = edges(b);
            d  = (ca > cb) ? ca - cb : cb - ca;
            r[i] = (ca > cb);
            u[i] = (d < THRESH);
        end
        return {r, u};
    endfunction

    // Monitor: pops expectations whenever done is presented, and checks ro_en burst lengths.
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(done), 0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = cyc_q.pop_front();
                chk("response", 32'(response), 32'(mon_e[7:4]));
                chk("unstable", 32'(unstable), 32'(mon_e[3:0]));
                chk("done_cycle", cyc, mon_c);
                chk("ro_en_in_done", 32'(ro_en), 0);
                chk("busy_in_done", 32'(busy), 1);
            end
        end
        if (ro_en === 1'b1) begin
            en_len++;
        end else if (en_len != 0) begin
            if (!skip_len) chk("ro_en_len", en_len, WINDOW + 1);
            en_len = 0;
        end
    end

    task automatic settle();
        repeat (8) tick();
    endtask

    task automatic run(input logic [CHAL_W-1:0] ch, input bit chaos);
        exp_q.push_back(model(ch));
        cyc_q.push_back(cyc + LAT);
        challenge = ch;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < LAT + 40 && exp_q.size() != 0; k++) begin
            if (chaos) begin
                challenge = CHAL_W'($urandom);
                start     = ((k % 50) == 17);
            end
            tick();
        end
        start = 1'b0;
        if (exp_q.size() != 0) begin
            chk("done_timeout", exp_q.size(), 0);
            exp_q.delete();
            cyc_q.delete();
        end
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        start     = 1'b1;
        challenge = '0;
        ro_in     = '0;
        repeat (3) begin
            tick();
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_ro_en", 32'(ro_en), 0);
            chk("rst_response", 32'(response), 0);
            chk("rst_unstable", 32'(unstable), 0);
        end
        rst   = 1'b0;
        start = 1'b0;
        tick();
        chk("busy_after_rst", 32'(busy), 0);

        // Start with enable low must be ignored.
        enable = 1'b0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        enable = 1'b1;
        chk("start_en0_ignored", 32'(busy), 0);

        // Basic: fast RO0 (period 4) vs slow RO1 (period 8).
        for (int i = 0; i < NUM_RO; i++) ph[i] = $urandom_range(0, 63);
        per[0]   = 4;
        per[1]   = 8;
        basic_ch = mkch(0, 1, 1, 0, 0, 1, 1, 0);
        settle();
        run(basic_ch, 1'b0);
        chk("basic_resp", 32'(response), 32'h5);
        repeat (10) tick();
        chk("hold_resp", 32'(response), 32'h5);
        chk("hold_unstable", 32'(unstable), 0);

        // Abort during bit 2 COUNT.
        challenge = basic_ch;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (149) tick();
        chk("abort_partial_resp", 32'(response), 32'h1);
        chk("abort_busy_before", 32'(busy), 1);
        skip_len = 1'b1;
        enable   = 1'b0;
        tick();
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ro_en", 32'(ro_en), 0);
        chk("abort_response", 32'(response), 0);
        chk("abort_unstable", 32'(unstable), 0);
        chk("abort_done", 32'(done), 0);
        enable = 1'b1;
        repeat (300) tick();
        skip_len = 1'b0;

        // Ties: same RO on both sides, and two idle ROs.
        per[2] = 6;
        per[3] = 0;
        per[4] = 0;
        settle();
        run(mkch(2, 2, 3, 4, 2, 2, 3, 4), 1'b0);
        chk("tie_resp", 32'(response), 0);
        chk("tie_unstable", 32'(unstable), 32'hf);

        // Start pulses and challenge changes while busy must not disturb the run.
        per[2] = 0;
        settle();
        run(basic_ch, 1'b1);
        chk("chaos_resp", 32'(response), 32'h5);
        chk("chaos_unstable", 32'(unstable), 0);

        // Random RO periods and challenges.
        repeat (8) begin
            for (int i = 0; i < NUM_RO; i++) begin
                per[i] = divs[$urandom_range(0, 6)];
                ph[i]  = $urandom_range(0, 63);
            end
            settle();
            run(CHAL_W'($urandom), 1'b0);
        end

        repeat (5) tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
